// File: rtl/whack_pkg.sv
// whack_pkg: session state encoding and score-driven difficulty tables
// shared by the whack-a-mole session logic.
package whack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      PLAY = 2'd2,
      OVER = 2'd3
   } session_state_t;

   localparam logic [7:0] LVL1_TH = 8'd5;
   localparam logic [7:0] LVL2_TH = 8'd10;
   localparam logic [7:0] LVL3_TH = 8'd20;

   localparam logic [15:0] PRESET_TBL [4] = '{16'd5000, 16'd4000, 16'd3000, 16'd2000};
   localparam logic [2:0] NUM_LIT_TBL [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

   function automatic logic [1:0] level_of(input logic [7:0] s);
      return s < LVL1_TH ? 2'd0 : s < LVL2_TH ? 2'd1 : s < LVL3_TH ? 2'd2 : 2'd3;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle tick every TICK_DIV enabled cycles;
// clr restarts the interval so the next tick is a full period away.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic clr,
   output logic tick
);

   localparam int W = $clog2(TICK_DIV);

   logic [W-1:0] cnt;

   assign tick = ena && cnt == W'(TICK_DIV - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (ena) cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/game_session_ctrl.sv
// game_session_ctrl: whack-a-mole session sequencer (idle, countdown, timed play,
// game over) with score-driven difficulty and a best-score register.
module game_session_ctrl
   import whack_pkg::*;
#(
   parameter int TICK_DIV  = 1000,
   parameter int GAME_MS   = 60000,
   parameter int ARM_MS    = 1000,
   parameter int ARM_STEPS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        start_btn,
   input  logic [7:0]  score,
   output logic [1:0]  state,
   output logic        play_en,
   output logic        fsm_rst_n,
   output logic        tick,
   output logic [15:0] time_left,
   output logic [1:0]  arm_digit,
   output logic [1:0]  level,
   output logic [15:0] round_preset,
   output logic [2:0]  num_lit,
   output logic [7:0]  high_score,
   output logic        new_high,
   output logic        game_over
);

   session_state_t cur, nxt;
   logic s1, s2, s3;
   logic [15:0] arm_cnt;
   logic start_rise, go, step_done, enter_arm, enter_play, enter_over;
   logic [1:0] lvl_nxt;

   // the synchroniser free-runs so a press during ena=0 is not half-captured
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1, s2, s3} <= '0;
      else {s1, s2, s3} <= {start_btn, s1, s2};

   assign start_rise = s2 & ~s3;
   assign go         = ena & start_rise;
   assign step_done  = tick && arm_cnt == 16'(ARM_MS - 1);
   assign enter_arm  = nxt == ARM && cur != ARM;
   assign enter_play = nxt == PLAY && cur == ARM;
   assign enter_over = nxt == OVER && cur == PLAY;
   assign lvl_nxt    = cur == PLAY ? level_of(score) : 2'd0;
   assign state      = cur;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .clr   (enter_arm | enter_play),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cur <= IDLE;
      else cur <= nxt;

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE: nxt = go ? ARM : IDLE;
         ARM:  nxt = step_done && arm_digit == 2'd1 ? PLAY : ARM;
         PLAY: nxt = tick && time_left == 16'd1 ? OVER : PLAY;
         OVER: nxt = go ? ARM : OVER;
      endcase
   end

   always_comb begin
      play_en   = cur == PLAY;
      fsm_rst_n = cur == PLAY || cur == OVER;
      game_over = cur == OVER;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         arm_cnt      <= '0;
         arm_digit    <= '0;
         time_left    <= '0;
         level        <= '0;
         round_preset <= PRESET_TBL[0];
         num_lit      <= NUM_LIT_TBL[0];
         high_score   <= '0;
         new_high     <= 1'b0;
      end else if (ena) begin
         new_high <= 1'b0;
         if (enter_arm) begin
            arm_cnt   <= '0;
            arm_digit <= 2'(ARM_STEPS);
         end else if (cur == ARM && tick) begin
            arm_cnt   <= step_done ? '0 : arm_cnt + 16'd1;
            arm_digit <= step_done ? arm_digit - 2'd1 : arm_digit;
         end
         if (enter_play) time_left <= 16'(GAME_MS);
         else if (cur == PLAY && tick) time_left <= time_left - 16'd1;
         if (enter_over && score > high_score) begin
            high_score <= score;
            new_high   <= 1'b1;
         end
         level        <= lvl_nxt;
         round_preset <= PRESET_TBL[lvl_nxt];
         num_lit      <= NUM_LIT_TBL[lvl_nxt];
      end

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
Top-level session sequencer for the whack-a-mole game. It owns the game lifecycle: idle, an armed 3-2-1 countdown, a timed play window, and game over. While play is active it runs the round machinery and drives its difficulty configuration (round timeout preset and number of lit moles) from the live score. It also keeps a best-score register that persists across games until reset.

Parameters:
TICK_DIV, 1000, clk cycles per 1 ms tick (legal range ≥2)
GAME_MS, 60000, play-window length in ticks (16-bit)
ARM_MS, 1000, ticks per countdown step
ARM_STEPS, 3, countdown start digit (1..3)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  global enable; 0 freezes all sequential state except the start synchroniser
start_btn  in  1  raw start button, asynchronous level
score  in  8  live score from the round FSM
state  out  2  session state: IDLE=0, ARM=1, PLAY=2, OVER=3
play_en  out  1  1 only in PLAY; enables the round timer and the pattern FSM
fsm_rst_n  out  1  active-low synchronous hold for the round FSM; 0 in IDLE and ARM
tick  out  1  one-cycle 1 ms strobe
time_left  out  16  remaining play ticks
arm_digit  out  2  countdown digit shown during ARM; 0 otherwise
level  out  2  difficulty level 0..3
round_preset  out  16  round timeout preset, in ticks
num_lit  out  3  lit moles per round
high_score  out  8  best final score
new_high  out  1  one-cycle pulse when high_score updates
game_over  out  1  1 in OVER

Behaviour:
- Reset values: state=IDLE, play_en=0, fsm_rst_n=0, tick=0, time_left=0, arm_digit=0, level=0, round_preset=5000, num_lit=1, high_score=0, new_high=0, game_over=0. The prescaler and synchroniser are cleared.
- Start input: two-flop synchroniser followed by a registered rising-edge detector, giving start_rise. Latency from a start_btn rise to the state change is 3 cycles. A level held high never produces a second edge.
- Prescaler: counts 0..TICK_DIV-1 while ena=1. tick=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0. The prescaler is zeroed on entry to ARM and to PLAY, so the first interval is always a full TICK_DIV cycles.
- IDLE: on start_rise, go to ARM and load arm_digit=ARM_STEPS.
- ARM:
  - A step counter counts ticks.
  - After ARM_MS ticks, arm_digit decrements.
  - When the final step (digit 1) expires, go to PLAY, load time_left=GAME_MS and set arm_digit=0.
  - start_rise is ignored.
- PLAY:
  - play_en=1 and fsm_rst_n=1.
  - time_left decrements on each tick.
  - A tick with time_left==1 sets time_left=0 and moves to OVER on the same edge.
  - start_rise is ignored.
- Entry to OVER:
  - The score value sampled on the transition edge is final_score.
  - If final_score > high_score, load high_score=final_score and pulse new_high for exactly one cycle.
  - If final_score equals high_score, nothing updates.
- OVER:
  - game_over=1.
  - play_en=0, so the round FSM freezes and score holds for display.
  - fsm_rst_n stays 1.
  - On start_rise, go to ARM with fsm_rst_n=0, which clears the score.
- Level, registered with one cycle latency from score:
  - score<5: level 0, preset 5000, num_lit 1.
  - score<10: level 1, preset 4000, num_lit 2.
  - score<20: level 2, preset 3000, num_lit 3.
  - otherwise: level 3, preset 2000, num_lit 4.
  - Outside PLAY, level is forced to 0.
- ena=0: state, prescaler, time_left, step counter and all registered outputs hold; tick=0. The synchroniser keeps running, but start_rise is consumed only when ena=1.
- Simultaneous events: a start_rise in the same cycle as the PLAY→OVER transition is ignored. A new edge is required to start again.
- rst_n asserted at any time (including mid-PLAY) returns to the reset values immediately; high_score is lost.

Decomposition:
- Package whack_pkg holds:
  - the session state enum;
  - level thresholds 5/10/20;
  - preset table 5000/4000/3000/2000;
  - num_lit table 1..4.
- One sub-module, tick_prescaler (params TICK_DIV; ports clk, rst_n, ena, clr, tick), is instantiated once.

Test Plan:
All scenarios use TICK_DIV=4, GAME_MS=10, ARM_MS=2, ARM_STEPS=3.
1. Reset: assert rst_n=0 with random inputs → all outputs at reset values, state=0, round_preset=5000.
2. Start: start_btn rises in IDLE → state=ARM 3 cycles later; arm_digit 3→2→1, changing every 8 cycles; state=PLAY 24 cycles after ARM entry; fsm_rst_n rises and time_left=10.
3. Timed end: hold score=7 through PLAY → time_left reaches 0 and state=OVER 40 cycles after PLAY entry; high_score=7; new_high high for exactly 1 cycle.
4. Difficulty: drive score 4, 5, 19, 20 in PLAY → level/preset/num_lit give 0/5000/1, 1/4000/2, 2/3000/3, 3/2000/4, each one cycle after the score change; in ARM, level=0.
5. Second game: restart from OVER, end with score=7, then a third game with score=3 → no new_high and high_score stays 7. Separately, start_btn held high across OVER → no restart.
6. Disruptions: ena=0 for 10 cycles mid-PLAY → time_left and state frozen, tick=0, countdown resumes afterwards; rst_n=0 mid-ARM → state=IDLE and high_score=0 immediately.
